prbs_frame_scheduler: RTL and testbench
=======================================

Name: prbs_frame_scheduler

Overview:
Sequences the 1-bit PRBS frame generator (data_gen) into a programmable burst of frames. Each frame is a 10-bit header, then a PRBS payload of configurable length, then an inter-frame gap. The block owns the generator's reset and send_enable, and flags which generator output bits are valid frame bits. It sits between the test-control register bank and data_gen, feeding the color-filter test transmitter.

Parameters:
CNT_W, 16, width of payload_len, gap_len, frame_count and frames_sent
HEAD_BITS, 10, header length in cycles; fixed by data_gen's header sequence
DEF_GAP, 4, gap length used when gap_len is sampled as 0

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a burst; sampled only in IDLE
stop  in  1  graceful stop request; level or pulse
frame_count  in  CNT_W  frames per burst; 0 = continuous until stop
payload_len  in  CNT_W  PRBS bits per frame; 0 = header-only frame
gap_len  in  CNT_W  gap cycles between frames; 0 -> DEF_GAP
gen_rst  out  1  drives data_gen.rst
gen_send_enable  out  1  drives data_gen.send_enable
frame_valid  out  1  high exactly when data_gen.data_out carries a header or payload bit
frame_sof  out  1  one-cycle pulse on the first header bit
frame_eof  out  1  one-cycle pulse on the last bit of the frame
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the burst ends
frames_sent  out  CNT_W  completed frames in the current or last burst

Behaviour:
- Reset values: state IDLE, gen_rst=1, all other outputs 0, frames_sent=0, stop_pend=0. Reset mid-frame aborts immediately, with no done pulse.
- Outputs are Moore-decoded from registered state and counters; there are no combinational input-to-output paths.
- States: IDLE, ARM, HEAD, PAYLOAD, GAP.
- IDLE: gen_rst=1.
  - On start: latch frame_count, payload_len and gap_len (0 -> DEF_GAP); clear frames_sent and stop_pend; go to ARM.
- ARM (1 cycle): gen_rst=0, gen_send_enable=1; go to HEAD.
  - data_gen samples send_enable at this edge, so its header starts in the next cycle.
- HEAD (HEAD_BITS cycles): frame_valid=1; frame_sof=1 in the first cycle.
  - Expected generator output is 1,1,0,0,1,1,0,0,1,1.
  - Exit to PAYLOAD, or to GAP if the latched payload_len=0.
- PAYLOAD (payload_len cycles): frame_valid=1.
  - gen_rst and gen_send_enable stay 0; data_gen self-enables its PRBS.
- frame_eof: asserted in the last HEAD cycle when payload_len=0, otherwise in the last PAYLOAD cycle. frames_sent increments at the same edge and saturates at all-ones.
- GAP (latched gap_len cycles): gen_rst=1 and frame_valid=0.
  - The first GAP cycle may still show PRBS on data_out; it is don't-care.
  - At gap end, if the burst is finished or stop_pend=1: go to IDLE and pulse done in the first IDLE cycle.
  - Otherwise go to ARM.
- Burst finished means frame_count != 0 and frames_sent == frame_count.
- Frame period = 1 (ARM) + HEAD_BITS + payload_len + gap.
- stop:
  - Any cycle with busy=1 sets stop_pend. The current frame always completes, including its gap.
  - stop in IDLE is ignored.
  - stop and start in the same IDLE cycle: start wins and stop_pend is cleared.
- start while busy is ignored. Config inputs are don't-care after latching.
- Counters: a single down-counter of width CNT_W is reloaded on every state entry; the state advances when it reaches 1. HEAD and ARM use constants. No arithmetic overflow is possible except frames_sent, which saturates.

Decomposition:
- Package prbs_frame_pkg:
  - state enum
  - HEAD_BITS=10
  - HEAD_PATTERN=10'b1100110011, used by the bench checker
  - DEF_GAP default
- Sub-module phase_counter: loadable down-counter with a "last" flag, shared by the HEAD, PAYLOAD and GAP phases.
- data_gen is instantiated alongside this block at the next level up, not inside it.

Test Plan:
- Nominal burst: frame_count=2, payload_len=20, gap_len=5, start pulse.
  - ARM one cycle after start; two frames with period 36 cycles.
  - 30 frame_valid cycles per frame; header 1100110011 each frame; PRBS payload identical in both frames because the generator is reset between frames.
  - done 1 cycle after the 2nd gap; frames_sent=2.
- Header-only and zero gap: payload_len=0, gap_len=0, frame_count=3.
  - frame_eof on the 10th header bit; gap lasts DEF_GAP=4 cycles; frame period 15; done after 3 frames.
- Continuous with stop: frame_count=0, payload_len=8.
  - Assert stop in the 3rd PAYLOAD cycle of frame 4.
  - Frame 4 completes, gap runs, then IDLE and done; frames_sent=4.
- Ignored inputs:
  - start during PAYLOAD has no effect.
  - Changing payload_len mid-burst does not change frame length.
  - stop in IDLE leaves busy=0.
  - stop and start in the same IDLE cycle starts the burst.
- Reset mid-operation: rst in cycle 5 of HEAD.
  - Next cycle: IDLE, gen_rst=1, frame_valid=0, frames_sent=0, no done pulse.
  - A new start produces a clean header.

Source files
------------

// File: rtl/prbs_frame_scheduler_pkg.sv
// PRBS frame scheduler shared types and constants.
// Header length and pattern follow data_gen's fixed header sequence.
package prbs_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HEAD,
    PAYLOAD,
    GAP
  } state_t;

  localparam int CNT_W = 16;
  localparam int HEAD_BITS = 10;
  localparam int DEF_GAP = 4;
  localparam logic [9:0] HEAD_PATTERN = 10'b1100110011;

endpackage

// File: rtl/prbs_frame_scheduler_if.sv
// Control and status bundle between register bank and scheduler.
// The register side is master; the scheduler is slave.
interface prbs_frame_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] payload_len;
  logic [CNT_W-1:0] gap_len;
  logic             gen_rst;
  logic             gen_send_enable;
  logic             frame_valid;
  logic             frame_sof;
  logic             frame_eof;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frames_sent;

  modport master (
    output start, stop, frame_count, payload_len, gap_len,
    input  gen_rst, gen_send_enable, frame_valid, frame_sof,
    input  frame_eof, busy, done, frames_sent
  );

  modport slave (
    input  start, stop, frame_count, payload_len, gap_len,
    output gen_rst, gen_send_enable, frame_valid, frame_sof,
    output frame_eof, busy, done, frames_sent
  );
endinterface

// File: rtl/prbs_frame_scheduler_phase_counter.sv
// Loadable down-counter timing each scheduler phase.
// last marks the final cycle of the current phase.
module phase_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         last
);

  // reload on phase entry, otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/prbs_frame_scheduler.sv
// Sequences data_gen into bursts of header + PRBS payload + gap.
// All outputs are decoded from registered state and counters.
module prbs_frame_scheduler
  import prbs_frame_pkg::*;
#(
  parameter int CNT_W     = prbs_frame_pkg::CNT_W,
  parameter int HEAD_BITS = prbs_frame_pkg::HEAD_BITS,
  parameter int DEF_GAP   = prbs_frame_pkg::DEF_GAP
) (
  input logic clk,
  input logic rst,
  prbs_frame_scheduler_if.slave bus
);

  state_t           state;
  state_t           nxt;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [CNT_W-1:0] fc_q;
  logic [CNT_W-1:0] pl_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] sent;
  logic             stop_pend;
  logic             done_q;
  logic             eof;
  logic             finished;

  phase_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .last     (last)
  );

  assign eof = (state == HEAD && last && pl_q == '0)
            || (state == PAYLOAD && last);

  assign finished = (fc_q != '0) && (sent == fc_q);

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // next state and phase counter reload
  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          nxt      = ARM;
          load     = 1'b1;
          load_val = CNT_W'(1);
        end
      end
      ARM: begin
        nxt      = HEAD;
        load     = 1'b1;
        load_val = CNT_W'(HEAD_BITS);
      end
      HEAD: begin
        if (last) begin
          load = 1'b1;
          if (pl_q == '0) begin
            nxt      = GAP;
            load_val = gap_q;
          end else begin
            nxt      = PAYLOAD;
            load_val = pl_q;
          end
        end
      end
      PAYLOAD: begin
        if (last) begin
          nxt      = GAP;
          load     = 1'b1;
          load_val = gap_q;
        end
      end
      GAP: begin
        if (last) begin
          if (finished || stop_pend) begin
            nxt = IDLE;
          end else begin
            nxt      = ARM;
            load     = 1'b1;
            load_val = CNT_W'(1);
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // config latch, stop request, frame count and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      fc_q      <= '0;
      pl_q      <= '0;
      gap_q     <= '0;
      sent      <= '0;
      stop_pend <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == GAP) && (nxt == IDLE);
      if (state == IDLE) begin
        if (bus.start) begin
          fc_q      <= bus.frame_count;
          pl_q      <= bus.payload_len;
          gap_q     <= (bus.gap_len == '0) ? CNT_W'(DEF_GAP)
                                           : bus.gap_len;
          sent      <= '0;
          stop_pend <= 1'b0;
        end
      end else begin
        if (bus.stop)
          stop_pend <= 1'b1;
        if (eof && sent != '1)
          sent <= sent + 1'b1;
      end
    end
  end

  assign bus.gen_rst         = (state == IDLE) || (state == GAP);
  assign bus.gen_send_enable = (state == ARM);
  assign bus.frame_valid     = (state == HEAD) || (state == PAYLOAD);
  assign bus.frame_sof       = (state == HEAD)
                            && (cnt == CNT_W'(HEAD_BITS));
  assign bus.frame_eof       = eof;
  assign bus.busy            = (state != IDLE);
  assign bus.done            = done_q;
  assign bus.frames_sent     = sent;

endmodule

// File: tb/tb_prbs_frame_scheduler.sv
// Directed bench for prbs_frame_scheduler.
// Records sof/eof/done cycle numbers and checks them against hand values.
module tb_prbs_frame_scheduler;
  import prbs_frame_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   nvalid = 0;
  int   sof_q[$];
  int   eof_q[$];
  int   done_q[$];
  int   s;

  prbs_frame_scheduler_if #(.CNT_W(16)) bus ();

  prbs_frame_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_sof)   sof_q.push_back(cyc);
      if (bus.frame_eof)   eof_q.push_back(cyc);
      if (bus.done)        done_q.push_back(cyc);
      if (bus.frame_valid) nvalid++;
    end
  end

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    sof_q.delete();
    eof_q.delete();
    done_q.delete();
    nvalid = 0;
  endtask

  task automatic start_burst(int fc, int pl, int gl, output int st);
    clr();
    bus.frame_count = 16'(fc);
    bus.payload_len = 16'(pl);
    bus.gap_len     = 16'(gl);
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    st = cyc;
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.frame_count = '0;
    bus.payload_len = '0;
    bus.gap_len     = '0;
    run(3);
    check("rst_busy", bus.busy, 0);
    check("rst_gen_rst", bus.gen_rst, 1);
    check("rst_send_en", bus.gen_send_enable, 0);
    check("rst_valid", bus.frame_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_sent", bus.frames_sent, 0);
    rst = 1'b0;
    run(2);

    // nominal burst
    start_burst(2, 20, 5, s);
    check("n_arm_send_en", bus.gen_send_enable, 1);
    check("n_arm_gen_rst", bus.gen_rst, 0);
    run(80);
    check("n_sof_cnt", sof_q.size(), 2);
    check("n_sof0", qat(sof_q, 0), s + 1);
    check("n_sof1", qat(sof_q, 1), s + 37);
    check("n_eof0", qat(eof_q, 0), s + 30);
    check("n_eof1", qat(eof_q, 1), s + 66);
    check("n_valid", nvalid, 60);
    check("n_done_cnt", done_q.size(), 1);
    check("n_done", qat(done_q, 0), s + 72);
    check("n_sent", bus.frames_sent, 2);
    check("n_busy", bus.busy, 0);

    // header-only frames with default gap
    start_burst(3, 0, 0, s);
    run(55);
    check("h_sof2", qat(sof_q, 2), s + 31);
    check("h_eof0", qat(eof_q, 0), s + 10);
    check("h_eof2", qat(eof_q, 2), s + 40);
    check("h_valid", nvalid, 30);
    check("h_done", qat(done_q, 0), s + 45);
    check("h_sent", bus.frames_sent, 3);

    // continuous with stop in 3rd payload cycle of frame 4
    start_burst(0, 8, 2, s);
    run(76);
    check("c_in_payload", bus.frame_valid, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    run(20);
    check("c_eof_cnt", eof_q.size(), 4);
    check("c_sof3", qat(sof_q, 3), s + 64);
    check("c_eof3", qat(eof_q, 3), s + 81);
    check("c_done", qat(done_q, 0), s + 84);
    check("c_sent", bus.frames_sent, 4);

    // start and payload_len change during payload are ignored
    start_burst(1, 20, 5, s);
    run(15);
    bus.start       = 1'b1;
    bus.payload_len = 16'd3;
    tick();
    bus.start = 1'b0;
    run(30);
    check("i_sof_cnt", sof_q.size(), 1);
    check("i_eof", qat(eof_q, 0), s + 30);
    check("i_done", qat(done_q, 0), s + 36);
    check("i_sent", bus.frames_sent, 1);

    // stop alone in idle does nothing
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("i_stop_idle_busy", bus.busy, 0);

    // stop with start in idle: start wins, burst runs to count
    clr();
    bus.frame_count = 16'd2;
    bus.payload_len = 16'd0;
    bus.gap_len     = 16'd0;
    bus.start       = 1'b1;
    bus.stop        = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    s = cyc;
    check("i_ss_busy", bus.busy, 1);
    run(40);
    check("i_ss_eof_cnt", eof_q.size(), 2);
    check("i_ss_done", qat(done_q, 0), s + 30);
    check("i_ss_sent", bus.frames_sent, 2);

    // reset in 5th header cycle
    start_burst(1, 4, 1, s);
    run(5);
    check("r_in_head", bus.frame_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_busy", bus.busy, 0);
    check("r_gen_rst", bus.gen_rst, 1);
    check("r_valid", bus.frame_valid, 0);
    check("r_sent", bus.frames_sent, 0);
    check("r_done", bus.done, 0);
    run(5);
    check("r_no_done", done_q.size(), 0);
    start_burst(1, 4, 1, s);
    run(25);
    check("r2_sof", qat(sof_q, 0), s + 1);
    check("r2_eof", qat(eof_q, 0), s + 14);
    check("r2_valid", nvalid, 14);
    check("r2_done", qat(done_q, 0), s + 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
